// File: rtl/fun_pkg.sv
// ============================================================================
// fun_pkg : shared widths, FSM state encoding and error code for fun_sched (rev 1.0)
// ============================================================================
`default_nettype none

package fun_pkg;
   localparam int OP_W  = 8;
   localparam int RES_W = 11;
   localparam int TAG_W = 4;

   localparam logic [RES_W-1:0] ERR_RESULT = 11'h7FF;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LAUNCH = 3'd1,
      ST_ARM    = 3'd2,
      ST_WAIT   = 3'd3,
      ST_DONE   = 3'd4
   } state_t;
endpackage

`default_nettype wire

// File: rtl/fun_sched_fifo.sv
// ============================================================================
// fun_sched_fifo : DEPTH-entry operand FIFO with full/empty flags (rev 1.0)
// ============================================================================
`default_nettype none

module fun_sched_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign rdata   = mem[rd_ptr];

   // DEPTH is a power of two, so the pointers wrap naturally
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end
endmodule

`default_nettype wire

// File: rtl/fun_sched.sv
// ============================================================================
// fun_sched : dispatches FIFO'd operand pairs one at a time to an a*cbrt(b) core (rev 1.0)
// Build macro FUN_SCHED_TIMEOUT_EN bounds the core wait to TIMEOUT cycles.
// ============================================================================
`default_nettype none

module fun_sched
   import fun_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 2000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  in_a,
   input  logic [OP_W-1:0]  in_b,
   output logic             core_start,
   output logic [OP_W-1:0]  core_a,
   output logic [OP_W-1:0]  core_b,
   input  logic             core_busy,
   input  logic [RES_W-1:0] core_result,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [RES_W-1:0] out_result,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_err
);
   state_t              state;
   logic                ready_en;
   logic                push;
   logic                pop;
   logic                fifo_full;
   logic                fifo_empty;
   logic [2*OP_W-1:0]   head;
   logic [TAG_W-1:0]    job_cnt;
   logic [TAG_W-1:0]    job_tag;

`ifdef FUN_SCHED_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT + 1);
   logic [TO_W-1:0]     wait_cnt;
`else
   assign out_err = 1'b0;
`endif

   // ready_en keeps in_ready low while reset is asserted
   assign in_ready = ready_en & ~fifo_full;
   assign push     = in_valid & in_ready;
   assign pop      = (state == ST_IDLE) & ~fifo_empty & (~out_valid | out_ready);

   fun_sched_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (2*OP_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .wdata ({in_a, in_b}),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_IDLE;
         ready_en   <= 1'b0;
         core_start <= 1'b0;
         core_a     <= '0;
         core_b     <= '0;
         out_valid  <= 1'b0;
         out_result <= '0;
         out_tag    <= '0;
         job_cnt    <= '0;
         job_tag    <= '0;
`ifdef FUN_SCHED_TIMEOUT_EN
         out_err    <= 1'b0;
         wait_cnt   <= '0;
`endif
      end else begin
         ready_en   <= 1'b1;
         core_start <= 1'b0;
         // a capture below overrides this drop in the same cycle
         if (out_valid && out_ready) out_valid <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (pop) begin
                  core_a     <= head[2*OP_W-1:OP_W];
                  core_b     <= head[OP_W-1:0];
                  job_tag    <= job_cnt;
                  job_cnt    <= job_cnt + 1'b1;
                  core_start <= 1'b1;
                  state      <= ST_LAUNCH;
               end
            end
            ST_LAUNCH: state <= ST_ARM;
            ST_ARM: begin
`ifdef FUN_SCHED_TIMEOUT_EN
               wait_cnt <= '0;
`endif
               state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (!core_busy) begin
                  out_result <= core_result;
                  out_tag    <= job_tag;
                  out_valid  <= 1'b1;
`ifdef FUN_SCHED_TIMEOUT_EN
                  out_err    <= 1'b0;
`endif
                  state      <= ST_DONE;
               end
`ifdef FUN_SCHED_TIMEOUT_EN
               else if (wait_cnt == TO_W'(TIMEOUT - 1)) begin
                  out_result <= ERR_RESULT;
                  out_tag    <= job_tag;
                  out_valid  <= 1'b1;
                  out_err    <= 1'b1;
                  state      <= ST_DONE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
`endif
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

`default_nettype wire

// File: tb/tb_fun_sched.sv
// ============================================================================
// tb_fun_sched : directed bench for fun_sched with a behavioural a*cbrt(b) core (rev 1.0)
// ============================================================================
`default_nettype none

module tb_fun_sched;
   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_a;
   logic [7:0]  in_b;
   logic        core_start;
   logic [7:0]  core_a;
   logic [7:0]  core_b;
   logic        core_busy;
   logic [10:0] core_result;
   logic        out_valid;
   logic        out_ready;
   logic [10:0] out_result;
   logic [3:0]  out_tag;
   logic        out_err;

   int checks = 0;
   int errors = 0;

   fun_sched #(
      .DEPTH   (4),
      .TIMEOUT (2000)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_a        (in_a),
      .in_b        (in_b),
      .core_start  (core_start),
      .core_a      (core_a),
      .core_b      (core_b),
      .core_busy   (core_busy),
      .core_result (core_result),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_result  (out_result),
      .out_tag     (out_tag),
      .out_err     (out_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // behavioural core: busy for core_a[1:0] cycles, force_busy holds it busy
   function automatic int icbrt(input int b);
      int r = 0;
      while ((r + 1) * (r + 1) * (r + 1) <= b) r++;
      return r;
   endfunction

   logic model_busy;
   logic force_busy;
   int   busy_left;

   assign core_result = 11'(int'(core_a) * icbrt(int'(core_b)));
   assign core_busy   = model_busy | force_busy;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         model_busy <= 1'b0;
         busy_left  <= 0;
      end else if (core_start) begin
         busy_left  <= int'(core_a[1:0]);
         model_busy <= (core_a[1:0] != 2'd0);
      end else if (busy_left > 0) begin
         busy_left  <= busy_left - 1;
         model_busy <= (busy_left > 1);
      end
   end

   // monitor: inputs only change at posedge+2, so negedge sees what the next edge sees
   logic [15:0] got_q[$];
   int          start_cnt = 0;

   always @(negedge clk) begin
      if (rst) begin
         if (out_valid && out_ready) got_q.push_back({out_err, out_tag, out_result});
         if (core_start) start_cnt <= start_cnt + 1;
      end
   end

   int rd_idx = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_pair(input logic [7:0] a, input logic [7:0] b, input int budget, output bit ok);
      ok = 1'b0;
      in_a = a;
      in_b = b;
      in_valid = 1'b1;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         if (in_ready) ok = 1'b1;
         @(posedge clk);
         #2;
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_results(input int n, input int budget);
      int i = 0;
      while ((got_q.size() - rd_idx) < n && i < budget) begin
         @(posedge clk);
         #2;
         i++;
      end
      check("result_wait", 32'((got_q.size() - rd_idx) >= n), 32'd1);
   endtask

   task automatic get_result(output logic [10:0] res, output logic [3:0] tag, output logic err);
      if (rd_idx < got_q.size()) begin
         {err, tag, res} = got_q[rd_idx];
         rd_idx++;
      end else begin
         {err, tag, res} = 'x;
      end
   endtask

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [10:0] res;
   } vec_t;

   vec_t vecs[8];
   vec_t fill[5];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          ok;
      int          n;
      int          base;
      int          accepted;
      logic [10:0] r;
      logic [3:0]  t;
      logic        e;

      vecs[0] = '{8'd3,   8'd64,  11'd12};
      vecs[1] = '{8'd9,   8'd125, 11'd45};
      vecs[2] = '{8'd255, 8'd216, 11'd1530};
      vecs[3] = '{8'd0,   8'd200, 11'd0};
      vecs[4] = '{8'd7,   8'd0,   11'd0};
      vecs[5] = '{8'd1,   8'd255, 11'd6};
      vecs[6] = '{8'd200, 8'd8,   11'd400};
      vecs[7] = '{8'd13,  8'd100, 11'd52};

      fill[0] = '{8'd1, 8'd1,   11'd1};
      fill[1] = '{8'd2, 8'd8,   11'd4};
      fill[2] = '{8'd3, 8'd27,  11'd9};
      fill[3] = '{8'd4, 8'd64,  11'd16};
      fill[4] = '{8'd5, 8'd125, 11'd25};

      // ---------------- reset ----------------
      rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
      out_ready = 1'b0; force_busy = 1'b0;
      #1 rst = 1'b0;
      #3;
      check("rst_in_ready",   32'(in_ready),   32'd0);
      check("rst_out_valid",  32'(out_valid),  32'd0);
      check("rst_core_start", 32'(core_start), 32'd0);
      check("rst_core_a",     32'(core_a),     32'd0);
      check("rst_core_b",     32'(core_b),     32'd0);
      check("rst_out_result", 32'(out_result), 32'd0);
      check("rst_out_tag",    32'(out_tag),    32'd0);
      check("rst_out_err",    32'(out_err),    32'd0);
      @(posedge clk); #2;
      rst = 1'b1;
      #1 check("in_ready_before_edge", 32'(in_ready), 32'd0);
      @(posedge clk); #2;
      check("in_ready_after_edge", 32'(in_ready), 32'd1);

      // ---------------- single job ----------------
      out_ready = 1'b1;
      base = start_cnt;
      push_pair(8'd5, 8'd27, 20, ok);
      check("single_push", 32'(ok), 32'd1);
      wait_results(1, 50);
      get_result(r, t, e);
      check("single_result", 32'(r), 32'd15);
      check("single_tag",    32'(t), 32'd0);
      check("single_err",    32'(e), 32'd0);
      repeat (5) begin @(posedge clk); #2; end
      check("single_starts", 32'(start_cnt - base), 32'd1);

      // ---------------- table, back-to-back ----------------
      for (int i = 0; i < 8; i++) begin
         push_pair(vecs[i].a, vecs[i].b, 50, ok);
         check("tbl_push", 32'(ok), 32'd1);
      end
      wait_results(8, 300);
      for (int i = 0; i < 8; i++) begin
         get_result(r, t, e);
         check("tbl_result", 32'(r), 32'(vecs[i].res));
         check("tbl_tag",    32'(t), 32'((i + 1) % 16));
         check("tbl_err",    32'(e), 32'd0);
      end

      // ---------------- minimum latency (zero busy) ----------------
      push_pair(8'd4, 8'd8, 20, ok);
      n = 0;
      while (!core_start && n < 20) begin @(negedge clk); n++; end
      check("lat_start_seen", 32'(core_start), 32'd1);
      n = 0;
      while (!out_valid && n < 20) begin @(negedge clk); n++; end
      check("lat_cycles", 32'(n), 32'd3);
      @(posedge clk); #2;
      wait_results(1, 20);
      get_result(r, t, e);
      check("lat_result", 32'(r), 32'd8);
      check("lat_tag",    32'(t), 32'd9);

      // ---------------- output backpressure ----------------
      out_ready = 1'b0;
      base = start_cnt;
      push_pair(8'd6, 8'd125, 20, ok);
      push_pair(8'd2, 8'd27, 20, ok);
      n = 0;
      while (!out_valid && n < 50) begin @(posedge clk); #2; n++; end
      for (int i = 0; i < 8; i++) begin
         check("bp_valid",  32'(out_valid),  32'd1);
         check("bp_result", 32'(out_result), 32'd30);
         @(posedge clk); #2;
      end
      check("bp_tag",    32'(out_tag), 32'd10);
      check("bp_starts", 32'(start_cnt - base), 32'd1);
      out_ready = 1'b1;
      wait_results(2, 50);
      get_result(r, t, e);
      check("bp_first",  32'({t, r}), 32'({4'd10, 11'd30}));
      get_result(r, t, e);
      check("bp_second", 32'({t, r}), 32'({4'd11, 11'd6}));
      check("bp_starts2", 32'(start_cnt - base), 32'd2);

      // ---------------- FIFO full with core stuck busy ----------------
      force_busy = 1'b1;
      accepted = 0;
      for (int i = 0; i < 5; i++) begin
         push_pair(fill[i].a, fill[i].b, 20, ok);
         accepted += int'(ok);
      end
      check("full_accepted", 32'(accepted), 32'd5);
      check("full_in_ready", 32'(in_ready), 32'd0);
      push_pair(8'd6, 8'd216, 10, ok);
      check("full_sixth_rejected", 32'(ok), 32'd0);
      force_busy = 1'b0;
      wait_results(5, 200);
      for (int i = 0; i < 5; i++) begin
         get_result(r, t, e);
         check("full_result", 32'(r), 32'(fill[i].res));
         check("full_tag",    32'(t), 32'((12 + i) % 16));
      end
      repeat (20) begin @(posedge clk); #2; end
      check("full_no_extra", 32'(got_q.size() - rd_idx), 32'd0);

      // ---------------- reset while waiting on the core ----------------
      force_busy = 1'b1;
      push_pair(8'd8, 8'd27, 20, ok);
      repeat (10) begin @(posedge clk); #2; end
      rst = 1'b0;
      #1;
      check("wrst_out_valid", 32'(out_valid), 32'd0);
      check("wrst_in_ready",  32'(in_ready),  32'd0);
      check("wrst_core_a",    32'(core_a),    32'd0);
      @(posedge clk);
      @(posedge clk); #2;
      rst = 1'b1;
      force_busy = 1'b0;
      @(posedge clk); #2;
      push_pair(8'd9, 8'd125, 20, ok);
      wait_results(1, 50);
      get_result(r, t, e);
      check("wrst_result", 32'(r), 32'd45);
      check("wrst_tag",    32'(t), 32'd0);
      check("wrst_err",    32'(e), 32'd0);
      repeat (15) begin @(posedge clk); #2; end
      check("wrst_no_stale", 32'(got_q.size() - rd_idx), 32'd0);

`ifdef FUN_SCHED_TIMEOUT_EN
      // ---------------- core timeout ----------------
      force_busy = 1'b1;
      push_pair(8'd1, 8'd1, 20, ok);
      n = 0;
      while (!core_start && n < 20) begin @(negedge clk); n++; end
      n = 0;
      while (!out_valid && n < 2100) begin @(negedge clk); n++; end
      check("to_cycles", 32'(n), 32'd2002);
      @(posedge clk); #2;
      force_busy = 1'b0;
      wait_results(1, 20);
      get_result(r, t, e);
      check("to_result", 32'(r), 32'h7FF);
      check("to_err",    32'(e), 32'd1);
      check("to_tag",    32'(t), 32'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

`default_nettype wire

// File: doc/fun_sched.md
FUN_SCHED -- requirements
Module: fun_sched

Interface
REQ-001 Parameter DEPTH, default 4, sets the operand FIFO entry count; it SHALL be a power of two, 2..16.
REQ-002 Parameter TIMEOUT, default 2000, sets the core-wait cycle limit (used only under FUN_SCHED_TIMEOUT_EN).
REQ-003 clk  input  1  the single clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  asynchronous reset, active-low.
REQ-005 in_valid  input  1  the upstream operand pair is valid.
REQ-006 in_ready  output  1  the FIFO can accept a pair.
REQ-007 in_a / in_b  input  8 each  multiplier a and radicand b.
REQ-008 core_start  output  1  one-cycle launch pulse to the a*cbrt(b) core.
REQ-009 core_a / core_b  output  8 each  operands to the core, held stable from start until the result is captured.
REQ-010 core_busy  input  1  the core is computing.
REQ-011 core_result  input  11  the core result, valid when core_busy is low after a launch.
REQ-012 out_valid  output  1  a result is held for downstream.
REQ-013 out_ready  input  1  the downstream consumer accepts the result.
REQ-014 out_result  output  11  captured result.
REQ-015 out_tag  output  4  job sequence number, modulo 16.
REQ-016 out_err  output  1  the job timed out.

Function
REQ-017 An input transfer SHALL occur when in_valid and in_ready are both high; in_ready SHALL equal "FIFO not full".
REQ-018 When the FIFO is full, in_ready SHALL be low and input SHALL be ignored; there SHALL be no overwrite.
REQ-019 The FSM states SHALL be IDLE, LAUNCH, ARM, WAIT and DONE.
REQ-020 IDLE -> LAUNCH SHALL occur when the FIFO is non-empty and out_valid is low (or out_valid and out_ready are both high in the same cycle); the FIFO head is popped and latched into core_a/core_b.
REQ-021 In LAUNCH, core_start SHALL be 1 for exactly one cycle, then the FSM SHALL go to ARM.
REQ-022 In ARM, core_busy SHALL be ignored for one cycle (the core may raise busy late), then the FSM SHALL go to WAIT.
REQ-023 In WAIT, core_busy low SHALL capture core_result into out_result, set out_valid, and go to DONE.
REQ-024 In DONE, the FSM SHALL return to IDLE in the next cycle.
REQ-025 The minimum latency from pop to out_valid SHALL be 3 cycles plus the core busy duration.
REQ-026 out_valid SHALL stay high, with out_result, out_tag and out_err stable, until out_ready is sampled high; it SHALL then drop unless a new capture occurs in the same cycle.
REQ-027 out_tag SHALL be a 4-bit job counter, incremented on each pop and wrapping 15 -> 0.
REQ-028 A simultaneous push and pop on a full FIFO SHALL NOT be possible, since in_ready is low; a simultaneous push and pop on a non-full FIFO SHALL keep the count unchanged.
REQ-029 Pairs SHALL be dispatched in strict FIFO order, with exactly one job in flight at a time.

Reset
REQ-030 Assertion of rst (low) SHALL immediately clear the FIFO pointers/count, set the FSM to IDLE, and drive core_start=0, core_a=0, core_b=0, out_valid=0, out_result=0, out_tag=0, out_err=0, in_ready=0.
REQ-031 After deassertion, in_ready SHALL go to 1 on the first clock edge.
REQ-032 Reset during WAIT SHALL abandon the job without producing any output.

Configuration
REQ-033 With FUN_SCHED_TIMEOUT_EN defined, a WAIT cycle counter SHALL run; when it reaches TIMEOUT with core_busy still high, the block SHALL capture out_result=11'h7FF and out_err=1, and go to DONE.
REQ-034 Without FUN_SCHED_TIMEOUT_EN, WAIT SHALL be unbounded, no counter SHALL exist, and out_err SHALL be tied to 0.

Structure
REQ-035 The package fun_pkg SHALL hold the operand width (8), result width (11), tag width (4), the FSM state enum, and the error result constant 11'h7FF.
REQ-036 The FIFO SHALL be the sub-module fun_sched_fifo (parameter DEPTH, data 16 bits, full/empty flags); the FSM and output register SHALL stay in fun_sched.

Verification
REQ-037 Push (5,27), hold out_ready=1, with the real core -> out_result=15, out_tag=0, out_err=0, and exactly one core_start pulse.
REQ-038 Push (3,64), (9,125) back-to-back -> results 12 then 45, tags 1 then 2, in order.
REQ-039 Push 5 pairs with the core held busy, DEPTH=4 -> in_ready goes low after 5 accepted (4 in FIFO, 1 in flight), and the 6th pair is not accepted.
REQ-040 Hold out_ready=0 after the first result -> out_valid stays 1 with the value stable, and no second core_start occurs until the handshake completes.
REQ-041 With FUN_SCHED_TIMEOUT_EN and TIMEOUT=2000, stub core_busy=1 -> after 2000 WAIT cycles, out_result=0x7FF and out_err=1.
REQ-042 Assert rst in WAIT, then push (9,125) -> no stale output appears, and the result is 45 with tag 0.
